// File: rtl/seq_divider.sv
`default_nettype none
// ============================================================================
// Module  : seq_divider
// Brief   : Multi-cycle signed restoring divider (2N-bit / N-bit -> N-bit q,r).
//           Optional macro DIV_SAT_EN saturates the quotient on overflow.
// Rev     : 1.0
// ============================================================================
module seq_divider #(
    parameter int N = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [2*N-1:0]   dividend,
    input  logic [N-1:0]     divisor,
    output logic             busy,
    output logic             done,
    output logic [N-1:0]     quotient,
    output logic [N-1:0]     remainder,
    output logic             div_by_zero,
    output logic             overflow
);

    localparam int CW = (N > 1) ? $clog2(N) : 1;
    localparam logic [N-1:0] c_QMAX = {1'b0, {(N-1){1'b1}}};
    localparam logic [N-1:0] c_QMIN = {1'b1, {(N-1){1'b0}}};

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_LOAD = 3'd1,
        S_CALC = 3'd2,
        S_FIX  = 3'd3,
        S_DONE = 3'd4
    } state_t;

    state_t          r_state;
    state_t          w_next;

    logic [2*N-1:0]  r_dvd;
    logic [N-1:0]    r_dvs;
    logic [N-1:0]    r_dvs_mag;
    logic [N-1:0]    r_rem;
    logic [N-1:0]    r_low;
    logic [N-1:0]    r_quo;
    logic [CW-1:0]   r_cnt;
    logic            r_qsign;
    logic            r_rsign;
    logic            r_dz;
    logic            r_pre_ovf;

    logic [2*N-1:0]  w_dvd_mag;
    logic [N-1:0]    w_dvs_mag;
    logic [N:0]      w_sh;
    logic [N:0]      w_trial;
    logic            w_fit;
    logic            w_ovf;

    assign w_dvd_mag = r_dvd[2*N-1] ? -r_dvd : r_dvd;
    assign w_dvs_mag = r_dvs[N-1]   ? -r_dvs : r_dvs;
    assign w_sh      = {r_rem, r_low[N-1]};
    assign w_trial   = w_sh - {1'b0, r_dvs_mag};
    // A negative quotient may reach -2^(N-1); a positive one stops at 2^(N-1)-1.
    assign w_fit     = r_qsign ? (r_quo <= c_QMIN) : ~r_quo[N-1];
    assign w_ovf     = ~r_dz & (r_pre_ovf | ~w_fit);

    always_ff @(posedge clk) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        busy   = 1'b0;
        done   = 1'b0;
        case (r_state)
            S_IDLE: if (start) w_next = S_LOAD;
            S_LOAD: begin
                busy   = 1'b1;
                w_next = S_CALC;
            end
            S_CALC: begin
                busy = 1'b1;
                if (r_cnt == CW'(N-1)) w_next = S_FIX;
            end
            S_FIX: begin
                busy   = 1'b1;
                w_next = S_DONE;
            end
            S_DONE: begin
                done   = 1'b1;
                w_next = S_IDLE;
            end
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_dvd       <= '0;
            r_dvs       <= '0;
            r_dvs_mag   <= '0;
            r_rem       <= '0;
            r_low       <= '0;
            r_quo       <= '0;
            r_cnt       <= '0;
            r_qsign     <= 1'b0;
            r_rsign     <= 1'b0;
            r_dz        <= 1'b0;
            r_pre_ovf   <= 1'b0;
            quotient    <= '0;
            remainder   <= '0;
            div_by_zero <= 1'b0;
            overflow    <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_dvd <= dividend;
                        r_dvs <= divisor;
                    end
                end
                S_LOAD: begin
                    // Upper half seeds the partial remainder; lower half is shifted in.
                    r_rem       <= w_dvd_mag[2*N-1:N];
                    r_low       <= w_dvd_mag[N-1:0];
                    r_dvs_mag   <= w_dvs_mag;
                    r_qsign     <= r_dvd[2*N-1] ^ r_dvs[N-1];
                    r_rsign     <= r_dvd[2*N-1];
                    r_dz        <= (r_dvs == '0);
                    r_pre_ovf   <= (w_dvd_mag[2*N-1:N] >= w_dvs_mag);
                    r_cnt       <= '0;
                    r_quo       <= '0;
                    quotient    <= '0;
                    remainder   <= '0;
                    div_by_zero <= 1'b0;
                    overflow    <= 1'b0;
                end
                S_CALC: begin
                    r_rem <= w_trial[N] ? w_sh[N-1:0] : w_trial[N-1:0];
                    r_quo <= {r_quo[N-2:0], ~w_trial[N]};
                    r_low <= {r_low[N-2:0], 1'b0};
                    r_cnt <= r_cnt + 1'b1;
                end
                S_FIX: begin
                    div_by_zero <= r_dz;
                    overflow    <= w_ovf;
                    if (r_dz) begin
                        quotient  <= '0;
                        remainder <= '0;
                    end else if (w_ovf) begin
`ifdef DIV_SAT_EN
                        quotient  <= r_qsign ? c_QMIN : c_QMAX;
`else
                        quotient  <= '0;
`endif
                        remainder <= '0;
                    end else begin
                        quotient  <= r_qsign ? -r_quo : r_quo;
                        remainder <= r_rsign ? -r_rem : r_rem;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_seq_divider.sv
`default_nettype none
// ============================================================================
// Module  : tb_seq_divider
// Brief   : Directed vector bench for seq_divider (N=3), incl. busy-path cases.
// Rev     : 1.0
// ============================================================================
module tb_seq_divider;

    localparam int N   = 3;
    localparam int LAT = N + 2;

    logic             clk = 1'b0;
    logic             rst;
    logic             start;
    logic [2*N-1:0]   dividend;
    logic [N-1:0]     divisor;
    logic             busy;
    logic             done;
    logic [N-1:0]     quotient;
    logic [N-1:0]     remainder;
    logic             div_by_zero;
    logic             overflow;

    int n_cmp  = 0;
    int n_fail = 0;

    seq_divider #(.N(N)) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .dividend    (dividend),
        .divisor     (divisor),
        .busy        (busy),
        .done        (done),
        .quotient    (quotient),
        .remainder   (remainder),
        .div_by_zero (div_by_zero),
        .overflow    (overflow)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [5:0] a;
        logic [2:0] b;
        logic [2:0] q;
        logic [2:0] r;
        logic       dz;
        logic       ov;
    } vec_t;

    vec_t tv[13];

`ifdef DIV_SAT_EN
    localparam logic [2:0] QOVP = 3'b011;
    localparam logic [2:0] QOVN = 3'b100;
`else
    localparam logic [2:0] QOVP = 3'b000;
    localparam logic [2:0] QOVN = 3'b000;
`endif

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Issue a one-cycle start, scramble the operand inputs afterwards, and
    // measure edges from T0 to done plus the number of busy samples.
    task automatic run_div(input logic [5:0] a, input logic [2:0] b,
                           output int lat, output int bcnt);
        lat  = 0;
        bcnt = 0;
        @(posedge clk); #1;
        start    = 1'b1;
        dividend = a;
        divisor  = b;
        @(posedge clk); #1;
        start    = 1'b0;
        dividend = 6'($urandom);
        divisor  = 3'($urandom);
        if (busy) bcnt++;
        for (int k = 1; k <= 12; k++) begin
            @(posedge clk); #1;
            if (busy) bcnt++;
            if (done) begin
                lat = k;
                break;
            end
        end
    endtask

    initial begin
        int lat, bcnt, ndone;
        rst = 1'b1; start = 1'b0; dividend = '0; divisor = '0;

        tv[0]  = '{6'b001010, 3'b011, 3'b011, 3'b001, 1'b0, 1'b0}; //  10 /  3
        tv[1]  = '{6'b110110, 3'b011, 3'b101, 3'b111, 1'b0, 1'b0}; // -10 /  3
        tv[2]  = '{6'b110100, 3'b011, 3'b100, 3'b000, 1'b0, 1'b0}; // -12 /  3
        tv[3]  = '{6'b010100, 3'b011, QOVP,   3'b000, 1'b0, 1'b1}; //  20 /  3
        tv[4]  = '{6'b000111, 3'b000, 3'b000, 3'b000, 1'b1, 1'b0}; //   7 /  0
        tv[5]  = '{6'b001001, 3'b100, 3'b110, 3'b001, 1'b0, 1'b0}; //   9 / -4
        tv[6]  = '{6'b111001, 3'b010, 3'b101, 3'b111, 1'b0, 1'b0}; //  -7 /  2
        tv[7]  = '{6'b100000, 3'b100, QOVP,   3'b000, 1'b0, 1'b1}; // -32 / -4
        tv[8]  = '{6'b011111, 3'b100, QOVN,   3'b000, 1'b0, 1'b1}; //  31 / -4
        tv[9]  = '{6'b111000, 3'b110, QOVP,   3'b000, 1'b0, 1'b1}; //  -8 / -2
        tv[10] = '{6'b000000, 3'b111, 3'b000, 3'b000, 1'b0, 1'b0}; //   0 / -1
        tv[11] = '{6'b111111, 3'b101, 3'b000, 3'b111, 1'b0, 1'b0}; //  -1 / -3
        tv[12] = '{6'b101010, 3'b000, 3'b000, 3'b000, 1'b1, 1'b0}; // -22 /  0

        repeat (2) @(posedge clk);
        #1;
        chk("reset_busy", busy, 0);
        chk("reset_done", done, 0);
        chk("reset_q", quotient, 0);
        chk("reset_r", remainder, 0);
        chk("reset_dz", div_by_zero, 0);
        chk("reset_ovf", overflow, 0);
        rst = 1'b0;

        for (int i = 0; i < 13; i++) begin
            run_div(tv[i].a, tv[i].b, lat, bcnt);
            chk($sformatf("v%0d_latency", i), lat, LAT);
            chk($sformatf("v%0d_busy_cycles", i), bcnt, LAT);
            chk($sformatf("v%0d_q", i), quotient, tv[i].q);
            chk($sformatf("v%0d_r", i), remainder, tv[i].r);
            chk($sformatf("v%0d_dz", i), div_by_zero, tv[i].dz);
            chk($sformatf("v%0d_ovf", i), overflow, tv[i].ov);
            @(posedge clk); #1;
            chk($sformatf("v%0d_done_pulse", i), done, 0);
            chk($sformatf("v%0d_q_hold", i), quotient, tv[i].q);
        end

        // start reissued mid-CALC must be ignored
        @(posedge clk); #1;
        start = 1'b1; dividend = 6'b001010; divisor = 3'b011;
        @(posedge clk); #1;
        start = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        start = 1'b1; dividend = 6'b000111; divisor = 3'b000;
        @(posedge clk); #1;
        start = 1'b0;
        lat = 0;
        for (int k = 4; k <= 12; k++) begin
            @(posedge clk); #1;
            if (done) begin
                lat = k;
                break;
            end
        end
        chk("ign_latency", lat, LAT);
        chk("ign_q", quotient, 3'b011);
        chk("ign_r", remainder, 3'b001);
        chk("ign_dz", div_by_zero, 0);
        ndone = 0;
        for (int k = 0; k < 10; k++) begin
            @(posedge clk); #1;
            if (done || busy) ndone++;
        end
        chk("ign_no_second_run", ndone, 0);

        // reset during CALC abandons the request
        @(posedge clk); #1;
        start = 1'b1; dividend = 6'b110110; divisor = 3'b011;
        @(posedge clk); #1;
        start = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        chk("rstmid_busy", busy, 0);
        chk("rstmid_done", done, 0);
        chk("rstmid_q", quotient, 0);
        chk("rstmid_r", remainder, 0);
        chk("rstmid_dz", div_by_zero, 0);
        chk("rstmid_ovf", overflow, 0);
        ndone = 0;
        for (int k = 0; k < 12; k++) begin
            @(posedge clk); #1;
            if (done) ndone++;
        end
        chk("rstmid_no_done", ndone, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
